// File: rtl/if_stage.sv
// Instruction-fetch stage: pre-IF next-PC generation, synchronous-read SRAM
// interface and a one-entry buffer that holds the fetched word while ID stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_allowin,
  input  logic [32:0] br_bus,
  output logic        if_validout,
  output logic [63:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  localparam int unsigned XLEN = 32;

  logic            preif_valid;
  logic            fs_valid;
  logic [XLEN-1:0] fs_pc;
  logic [XLEN-1:0] inst_buf;
  logic            inst_buf_valid;

  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] nextpc;
  logic [XLEN-1:0] inst;
  logic            fs_allowin;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  // A redirect kills whatever sits in IF, so it can always be overwritten.
  assign fs_allowin = ~fs_valid | id_allowin | br_taken;
  assign nextpc     = br_taken ? br_target : fs_pc + XLEN'(4);

  assign inst_sram_en    = preif_valid & fs_allowin;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;
  assign inst_sram_addr  = rst ? RESET_PC : nextpc;

  assign inst         = inst_buf_valid ? inst_buf : inst_sram_rdata;
  assign if_validout  = fs_valid & ~br_taken;
  assign if_to_id_bus = {fs_pc, inst};

  // SRAM output is not held while en=0, so the word is captured on the first stall edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preif_valid    <= 1'b0;
      fs_valid       <= 1'b0;
      fs_pc          <= RESET_PC - XLEN'(4);
      inst_buf       <= '0;
      inst_buf_valid <= 1'b0;
    end else begin
      preif_valid <= 1'b1;
      if (inst_sram_en) begin
        fs_pc          <= nextpc;
        fs_valid       <= 1'b1;
        inst_buf_valid <= 1'b0;
      end else if (fs_valid & ~id_allowin & ~br_taken & ~inst_buf_valid) begin
        inst_buf       <= inst_sram_rdata;
        inst_buf_valid <= 1'b1;
      end
    end
  end

endmodule
